// File: rtl/fifo_drain_reader.sv
// fifo_drain_reader: read-side controller for the synchronous FIFO.
// Issues fifo_rd_en, captures the word one cycle later into a small skid
// buffer, and presents the buffer head on a valid/ready stream.
// Optional statistics counters are enabled with `define FIFO_RD_STATS_EN.
module fifo_drain_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  err_underflow
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]           rd_count,
  output logic [15:0]           uf_count
`endif
);

  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(BUF_DEPTH - 1);
  localparam logic [OW:0]   DEPTH_W  = (OW + 1)'(BUF_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state, state_nxt;
  logic [OW-1:0]         occ;
  logic                  inflight;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic                  push, pop, uf_hit;

  // Reads are gated only by state and reserved buffer space, never by
  // m_ready, so the downstream ready path stays out of the FIFO read path.
  assign fifo_rd_en = (state == RUN) & ~fifo_empty & ~flush &
                      (({1'b0, occ} + (OW + 1)'(inflight)) < DEPTH_W);

  // A word returning during a flush is dropped along with the buffer.
  assign push    = inflight & ~fifo_underflow & ~flush;
  assign uf_hit  = inflight &  fifo_underflow & ~flush;
  assign m_valid = (occ != '0);
  assign pop     = m_valid & m_ready;
  // Head is forced to zero when empty so m_data reads 0 out of reset.
  assign m_data  = m_valid ? mem[rd_ptr] : '0;
  assign busy    = (state != IDLE) | m_valid | inflight;

  // Next-state: flush wins over everything, DRAIN exits once fully emptied.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (en) state_nxt = RUN;
        RUN:     if (!en) state_nxt = DRAIN;
        DRAIN: begin
          if (en)                              state_nxt = RUN;
          else if (!inflight && occ == '0)     state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Control state: FSM, in-flight flag, occupancy, pointers, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      inflight      <= 1'b0;
      occ           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      err_underflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en;
      if (flush) begin
        occ           <= '0;
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        err_underflow <= 1'b0;
      end else begin
        if (push && !pop)      occ <= occ + 1'b1;
        else if (pop && !push) occ <= occ - 1'b1;
        if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
        if (uf_hit) err_underflow <= 1'b1;
      end
    end
  end

  // Skid buffer storage; contents are qualified by occ so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fifo_data_out;
  end

`ifdef FIFO_RD_STATS_EN
  // Delivery and underflow counters; cleared by rst only, not by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      uf_count <= '0;
    end else begin
      if (pop) rd_count <= rd_count + 32'd1;
      if (uf_hit && uf_count != 16'hFFFF) uf_count <= uf_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_drain_reader.sv
// tb_fifo_drain_reader: directed bench for fifo_drain_reader.
// A behavioural FIFO feeds the DUT; inputs change on negedge and outputs
// are compared 1 ns later. Stats ports are checked when FIFO_RD_STATS_EN.
module tb_fifo_drain_reader;

  logic        clk = 1'b0;
  logic        rst, en, flush, m_ready, uf, fclr;
  logic        fifo_rd_en, fifo_empty, m_valid, busy, err_underflow;
  logic [15:0] fifo_data_out = 16'h0;
  logic [15:0] m_data;
`ifdef FIFO_RD_STATS_EN
  logic [31:0] rd_count;
  logic [15:0] uf_count;
`endif

  int passed = 0;
  int total  = 0;

  logic [15:0] fmem [64];
  int wr_idx = 0;
  int rd_idx = 0;

  always #5 clk = ~clk;

  fifo_drain_reader #(.DATA_WIDTH(16), .BUF_DEPTH(3)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .fifo_underflow(uf),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .err_underflow(err_underflow)
`ifdef FIFO_RD_STATS_EN
    , .rd_count(rd_count), .uf_count(uf_count)
`endif
  );

  // Behavioural FIFO: data appears the cycle after a read request.
  assign fifo_empty = (rd_idx == wr_idx);
  always @(posedge clk) begin
    if (fclr) rd_idx <= wr_idx;
    else if (fifo_rd_en && rd_idx != wr_idx) begin
      fifo_data_out <= fmem[rd_idx % 64];
      rd_idx        <= rd_idx + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  task automatic load(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_idx % 64] = base + 16'(i);
      wr_idx++;
    end
  endtask

  task automatic fifo_clear();
    fclr = 1'b1;
    @(negedge clk);
    fclr = 1'b0;
  endtask

  typedef struct {
    logic        en, rdy;
    logic        rd, mv;
    logic [15:0] md;
    logic        bsy, err;
  } vec_t;
  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nrd;
    // Streaming 5 words with m_ready held; en dropped once FIFO empties.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h00A0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h00A1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h00A2, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h00A3, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h00A4, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};

    rst = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0; uf = 1'b0; fclr = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; #1;
    chk("reset_state", {fifo_rd_en, m_valid, m_data, busy, err_underflow}, 32'h0);

    load(16'h00A0, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      en = vecs[i].en; m_ready = vecs[i].rdy; #1;
      chk($sformatf("stream_v%0d", i),
          {fifo_rd_en, m_valid, m_data, busy, err_underflow},
          {vecs[i].rd, vecs[i].mv, vecs[i].md, vecs[i].bsy, vecs[i].err});
    end
`ifdef FIFO_RD_STATS_EN
    chk("stats_rd5", rd_count, 32'd5);
`endif

    // Backpressure: only BUF_DEPTH reads while stalled, then gap-free drain.
    load(16'h00B0, 8);
    nrd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); en = 1'b1; m_ready = 1'b0; #1;
      nrd += int'(fifo_rd_en);
    end
    chk("bp_reads", nrd, 3);
    chk("bp_hold", {m_valid, m_data}, {1'b1, 16'h00B0});
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); m_ready = 1'b1; #1;
      chk($sformatf("bp_word%0d", k), {m_valid, m_data}, {1'b1, 16'h00B0 + 16'(k)});
    end
    en = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("bp_idle", {busy, m_valid}, 2'b00);

    // DRAIN: en dropped with a read outstanding.
    load(16'h00D0, 3);
    @(negedge clk); en = 1'b1; m_ready = 1'b1; #1;
    chk("dr_idle", fifo_rd_en, 1'b0);
    @(negedge clk); en = 1'b0; #1;
    chk("dr_read", fifo_rd_en, 1'b1);
    @(negedge clk); #1;
    chk("dr_inflight", {fifo_rd_en, m_valid, busy}, 3'b001);
    @(negedge clk); m_ready = 1'b0; #1;
    chk("dr_word", {m_valid, m_data, busy}, {1'b1, 16'h00D0, 1'b1});
    @(negedge clk); #1;
    chk("dr_hold", {m_valid, m_data, busy}, {1'b1, 16'h00D0, 1'b1});
    @(negedge clk); m_ready = 1'b1; #1;
    chk("dr_pop", {m_valid, m_data}, {1'b1, 16'h00D0});
    @(negedge clk); #1;
    chk("dr_empty_busy", {m_valid, busy}, 2'b01);
    @(negedge clk); #1;
    chk("dr_to_idle", {busy, fifo_rd_en}, 2'b00);
    fifo_clear();

    // Underflow on the capture cycle.
    load(16'h00E0, 1);
    @(negedge clk); en = 1'b1; #1;
    @(negedge clk); #1;
    chk("uf_read", fifo_rd_en, 1'b1);
    @(negedge clk); en = 1'b0; uf = 1'b1; #1;
    chk("uf_capture", {m_valid, err_underflow}, 2'b00);
    @(negedge clk); uf = 1'b0; #1;
    chk("uf_set", {m_valid, err_underflow}, 2'b01);
    @(negedge clk); #1;
    chk("uf_idle", {busy, err_underflow}, 2'b01);
    @(negedge clk); #1;
    chk("uf_sticky", err_underflow, 1'b1);
`ifdef FIFO_RD_STATS_EN
    chk("stats_uf1", uf_count, 16'd1);
`endif

    // Flush with two buffered words and one read in flight.
    load(16'h00F0, 4);
    m_ready = 1'b0;
    @(negedge clk); en = 1'b1; #1;
    chk("fl_err_before", {fifo_rd_en, err_underflow}, 2'b01);
    @(negedge clk); #1; chk("fl_rd0", fifo_rd_en, 1'b1);
    @(negedge clk); #1; chk("fl_rd1", fifo_rd_en, 1'b1);
    @(negedge clk); #1;
    chk("fl_rd2", {fifo_rd_en, m_valid, m_data}, {1'b1, 1'b1, 16'h00F0});
    @(negedge clk); flush = 1'b1; #1;
    chk("fl_same", {fifo_rd_en, m_valid, m_data}, {1'b0, 1'b1, 16'h00F0});
    @(negedge clk); flush = 1'b0; m_ready = 1'b1; #1;
    chk("fl_next", {m_valid, err_underflow, busy, fifo_rd_en}, 4'b0000);
    @(negedge clk); #1; chk("fl_reread", fifo_rd_en, 1'b1);
    @(negedge clk); #1; chk("fl_gap", m_valid, 1'b0);
    @(negedge clk); #1;
    chk("fl_fresh", {m_valid, m_data}, {1'b1, 16'h00F3});
    en = 1'b0;
    repeat (3) @(negedge clk);

    // Reset pulse in the middle of a stream.
    load(16'h0C00, 4);
    @(negedge clk); en = 1'b1; m_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    @(negedge clk); #1;
    chk("rs_stream", {m_valid, m_data}, {1'b1, 16'h0C00});
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; en = 1'b0; #1;
    chk("rs_after", {fifo_rd_en, m_valid, m_data, busy, err_underflow}, 32'h0);
`ifdef FIFO_RD_STATS_EN
    chk("stats_rd_rst", rd_count, 32'd0);
`endif
    fifo_clear();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
